// File: rtl/lrelu_pkg.sv
// rtl/lrelu_pkg.sv - fixed-point types and product scaling for the leaky ReLU backward unit.
// Build option: LRELU_BWD_SAT_EN selects clamping instead of two's-complement wrap.
package lrelu_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 8;

  typedef logic signed [WIDTH-1:0]   fixed_t;
  typedef logic signed [2*WIDTH-1:0] fixed_wide_t;

  localparam fixed_wide_t SAT_MAX = fixed_wide_t'((2 ** (WIDTH - 1)) - 1);
  localparam fixed_wide_t SAT_MIN = fixed_wide_t'(-(2 ** (WIDTH - 1)));

  // Arithmetic shift floors toward -inf; only the clamp differs between builds.
  function automatic fixed_t scale_sat(fixed_wide_t p);
    fixed_wide_t s;
    s = p >>> FRAC_BITS;
`ifdef LRELU_BWD_SAT_EN
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
`else
    s = s;
`endif
    return fixed_t'(s);
  endfunction

endpackage

// File: rtl/leaky_relu_backward_if.sv
// rtl/leaky_relu_backward_if.sv - cache push, gradient, result and control signals of leaky_relu_backward.
interface leaky_relu_backward_if #(parameter int DEPTH = 16);
  import lrelu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fixed_t          leak_factor;
  logic            flush;
  logic            fwd_valid;
  logic            fwd_ready;
  fixed_t          fwd_z;
  logic            grad_valid;
  logic            grad_ready;
  fixed_t          grad_in;
  logic            out_valid;
  logic            out_ready;
  fixed_t          out_data;
  logic [CW-1:0]   cache_count;

  modport slave (
    input  leak_factor, flush, fwd_valid, fwd_z, grad_valid, grad_in, out_ready,
    output fwd_ready, grad_ready, out_valid, out_data, cache_count
  );

  modport master (
    output leak_factor, flush, fwd_valid, fwd_z, grad_valid, grad_in, out_ready,
    input  fwd_ready, grad_ready, out_valid, out_data, cache_count
  );

endinterface

// File: rtl/lrelu_cache_fifo.sv
// rtl/lrelu_cache_fifo.sv - DEPTH x WIDTH synchronous FIFO caching forward pre-activations.
module lrelu_cache_fifo
  import lrelu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fixed_t                   data_i,
  input  logic                     pop_i,
  output fixed_t                   data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  fixed_t        mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/leaky_relu_backward.sv
// rtl/leaky_relu_backward.sv - leaky ReLU backward pass: z cache feeding a stall-together gradient pipeline.
// Output scaling honours LRELU_BWD_SAT_EN through lrelu_pkg::scale_sat.
module leaky_relu_backward #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  leaky_relu_backward_if.slave   bus
);
  import lrelu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  fixed_t        head_z;
  logic          en, push, pop;

  logic          in_valid_q, in_pass_q;
  fixed_t        in_g_q, in_leak_q;
  logic          s1_valid_q, s1_pass_q;
  fixed_t        s1_g_q;
  fixed_wide_t   s1_prod_q, s1_prod_d;
  logic          out_valid_q;
  fixed_t        out_data_q, out_data_d;

  assign en   = !out_valid_q || bus.out_ready;
  assign push = bus.fwd_valid && bus.fwd_ready;
  assign pop  = bus.grad_valid && bus.grad_ready;

  assign bus.fwd_ready   = (count < CW'(DEPTH)) && !bus.flush;
  assign bus.grad_ready  = en && (count != '0) && !bus.flush;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.cache_count = count;

  lrelu_cache_fifo #(.DEPTH(DEPTH)) u_cache (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.flush),
    .push_i  (push),
    .data_i  (bus.fwd_z),
    .pop_i   (pop),
    .data_o  (head_z),
    .count_o (count)
  );

  always_comb begin
    s1_prod_d  = fixed_wide_t'(in_g_q) * fixed_wide_t'(in_leak_q);
    out_data_d = s1_pass_q ? s1_g_q : scale_sat(s1_prod_q);
  end

  // Operands (with leak) are captured on accept; S1 multiplies, S2 scales into out_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_q  <= 1'b0;
      in_pass_q   <= 1'b0;
      in_g_q      <= '0;
      in_leak_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_pass_q   <= 1'b0;
      s1_g_q      <= '0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      in_valid_q <= pop;
      if (pop) begin
        in_g_q    <= bus.grad_in;
        in_leak_q <= bus.leak_factor;
        in_pass_q <= !head_z[WIDTH-1] && (head_z != '0);
      end
      s1_valid_q <= in_valid_q;
      if (in_valid_q) begin
        s1_g_q    <= in_g_q;
        s1_pass_q <= in_pass_q;
        s1_prod_q <= s1_prod_d;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_leaky_relu_backward.sv
// tb/tb_leaky_relu_backward.sv - self-checking bench for leaky_relu_backward against a queue-based model.
module tb_leaky_relu_backward;
  import lrelu_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  leaky_relu_backward_if #(.DEPTH(DEPTH)) bus();
  leaky_relu_backward #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int outs_seen = 0;
  logic grad_acc, fwd_acc;
  logic hold_pending;
  logic [15:0] hold_data;
  logic [15:0] z_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] z;
    logic [15:0] g;
    logic [15:0] leak;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] ref_out(input logic [15:0] z, input logic [15:0] g, input logic [15:0] leak);
    longint zs, gs, ls, p;
    zs = longint'($signed(z));
    gs = longint'($signed(g));
    ls = longint'($signed(leak));
    if (zs > 0) return g;
    p = (gs * ls) >>> 8;
`ifdef LRELU_BWD_SAT_EN
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
`endif
    return p[15:0];
  endfunction

  // One cycle: inputs were set at the preceding negedge; observe, update model, advance.
  task automatic tick();
    #1;
    if (hold_pending) begin
      chk("out_hold_valid", {31'd0, bus.out_valid}, 1);
      chk("out_hold_data", {16'd0, bus.out_data}, {16'd0, hold_data});
    end
    chk("cache_count", {27'd0, bus.cache_count}, z_q.size());
    chk("fwd_ready", {31'd0, bus.fwd_ready}, {31'd0, (z_q.size() < DEPTH) && !bus.flush});
    if (z_q.size() == 0 || bus.flush) chk("grad_ready_blocked", {31'd0, bus.grad_ready}, 0);
    if (bus.out_valid && !bus.out_ready) chk("grad_ready_stall", {31'd0, bus.grad_ready}, 0);
    grad_acc = bus.grad_valid && bus.grad_ready;
    fwd_acc  = bus.fwd_valid && bus.fwd_ready;
    if (grad_acc) begin
      if (z_q.size() == 0) chk("grad_underflow", 1, 0);
      else exp_q.push_back(ref_out(z_q.pop_front(), bus.grad_in, bus.leak_factor));
    end
    if (fwd_acc) z_q.push_back(bus.fwd_z);
    if (bus.out_valid && bus.out_ready) begin
      outs_seen++;
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else chk("out_data", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
    end
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_data    = bus.out_data;
    if (bus.flush) z_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, sent, base;
    bus.leak_factor = 16'h0040;
    bus.flush = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.fwd_z = '0;
    bus.grad_valid = 1'b0;
    bus.grad_in = '0;
    bus.out_ready = 1'b1;
    hold_pending = 1'b0;
    hold_data = '0;
    grad_acc = 1'b0;
    fwd_acc = 1'b0;
    rst = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_out_data", {16'd0, bus.out_data}, 0);
    chk("rst_cache_count", {27'd0, bus.cache_count}, 0);
    chk("rst_grad_ready", {31'd0, bus.grad_ready}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors: push z, present g, expect result two edges after the accept edge.
    vecs.push_back('{16'h0100, 16'h0200, 16'h0040, 16'h0200});
    vecs.push_back('{16'hFF00, 16'h0200, 16'h0040, 16'h0080});
    vecs.push_back('{16'h0000, 16'h0400, 16'h0040, 16'h0100});
    vecs.push_back('{16'h0001, 16'h8000, 16'h0040, 16'h8000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0040, 16'hFFFF});
`ifdef LRELU_BWD_SAT_EN
    vecs.push_back('{16'hFF00, 16'h7000, 16'h0200, 16'h7FFF});
    vecs.push_back('{16'hFF00, 16'h9000, 16'h0200, 16'h8000});
`else
    vecs.push_back('{16'hFF00, 16'h7000, 16'h0200, 16'hE000});
    vecs.push_back('{16'hFF00, 16'h9000, 16'h0200, 16'h2000});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_z = vecs[i].z;
      tick();
      bus.fwd_valid = 1'b0;
      bus.grad_valid = 1'b1;
      bus.grad_in = vecs[i].g;
      bus.leak_factor = vecs[i].leak;
      tick();
      bus.grad_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 10) begin
        tick();
        k++;
      end
      chk($sformatf("vec%0d_latency", i), k, 2);
      chk($sformatf("vec%0d_result", i), {16'd0, bus.out_data}, {16'd0, vecs[i].res});
      tick();
    end
    bus.leak_factor = 16'h0040;

    // Empty cache: gradient must wait; one pushed z yields exactly one result.
    bus.grad_valid = 1'b1;
    bus.grad_in = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      chk("empty_grad_ready", {31'd0, bus.grad_ready}, 0);
      chk("empty_out_valid", {31'd0, bus.out_valid}, 0);
      tick();
    end
    base = outs_seen;
    bus.fwd_valid = 1'b1;
    bus.fwd_z = 16'hFE00;
    tick();
    bus.fwd_valid = 1'b0;
    tick();
    bus.grad_valid = 1'b0;
    repeat (6) tick();
    chk("empty_one_result", outs_seen - base, 1);

    // Backpressure: 8 gradients with out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_z = 16'($urandom);
      tick();
    end
    bus.fwd_valid = 1'b0;
    bus.leak_factor = 16'($urandom);
    base = outs_seen;
    sent = 0;
    bus.grad_in = 16'($urandom);
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.grad_valid = (sent < 8);
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      tick();
      if (grad_acc) begin
        sent++;
        bus.grad_in = 16'($urandom);
      end
    end
    bus.grad_valid = 1'b0;
    drain("bp_drained");
    chk("bp_count", outs_seen - base, 8);

    // Randomised soak with random valids, backpressure, leak changes and rare flushes.
    bus.fwd_valid = 1'b0;
    bus.grad_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.fwd_valid || fwd_acc) begin
        bus.fwd_valid = 1'($urandom_range(0, 1));
        bus.fwd_z = 16'($urandom);
      end
      if (!bus.grad_valid || grad_acc) begin
        bus.grad_valid = 1'($urandom_range(0, 1));
        bus.grad_in = 16'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 15) == 0) bus.leak_factor = 16'($urandom);
      fwd_acc = 1'b0;
      grad_acc = 1'b0;
      tick();
    end
    bus.fwd_valid = 1'b0;
    bus.grad_valid = 1'b0;
    bus.flush = 1'b0;
    drain("soak_drained");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // Fill to DEPTH, push+pop at DEPTH-1, then flush with results in flight.
    bus.fwd_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fwd_z = 16'($urandom);
      tick();
    end
    chk("full_count", {27'd0, bus.cache_count}, DEPTH);
    chk("full_fwd_ready", {31'd0, bus.fwd_ready}, 0);
    tick();
    bus.fwd_valid = 1'b0;
    bus.grad_valid = 1'b1;
    bus.grad_in = 16'($urandom);
    tick();
    bus.fwd_valid = 1'b1;
    bus.fwd_z = 16'($urandom);
    bus.grad_in = 16'($urandom);
    tick();
    chk("pushpop_count", {27'd0, bus.cache_count}, DEPTH - 1);
    bus.fwd_valid = 1'b0;
    bus.grad_in = 16'($urandom);
    tick();
    bus.grad_valid = 1'b0;
    bus.flush = 1'b1;
    bus.fwd_valid = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.fwd_valid = 1'b0;
    chk("flush_count", {27'd0, bus.cache_count}, 0);
    drain("flush_inflight_drained");

    // Asynchronous reset with a result pending and three entries cached.
    bus.fwd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.fwd_z = 16'($urandom);
      tick();
    end
    bus.fwd_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.grad_valid = 1'b1;
    sent = 0;
    k = 0;
    while (sent < 2 && k < 10) begin
      bus.grad_in = 16'($urandom);
      tick();
      if (grad_acc) sent++;
      k++;
    end
    bus.grad_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 1);
    chk("pre_rst_count", {27'd0, bus.cache_count}, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("async_rst_out_data", {16'd0, bus.out_data}, 0);
    chk("async_rst_count", {27'd0, bus.cache_count}, 0);
    z_q.delete();
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    base = outs_seen;
    repeat (6) tick();
    chk("post_rst_no_output", outs_seen - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
